// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: next-PC selects,
// fetch FSM states and the IF/ID register layout.
package fetch_unit_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'd0;
    localparam logic [1:0] PCSEL_BR   = 2'd1;
    localparam logic [1:0] PCSEL_JMP  = 2'd2;
    localparam logic [1:0] PCSEL_HOLD = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2
    } fetch_state_t;

    // One IF/ID entry; the skid buffer uses the same layout.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

endpackage

// File: rtl/pc_next_mux.sv
// Pure 4:1 next-PC selector; the fetch unit owns every register.
module pc_next_mux
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  pcsel,
    input  logic [31:0] pcp4,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic [31:0] pcp4_hold,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pcp4;
        case (pcsel)
            PCSEL_SEQ:  next_pc = pcp4;
            PCSEL_BR:   next_pc = br_target;
            PCSEL_JMP:  next_pc = jmp_target;
            PCSEL_HOLD: next_pc = pcp4_hold;
            default:    next_pc = pcp4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, memory handshake, IF/ID register
// and a one-entry skid buffer for responses that decode cannot take yet.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pcsel,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic [31:0] pcp4_hold,
    input  logic        if_id_stall,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcp4,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         pending;
    logic         xfer;
    ifid_t        ifid;
    ifid_t        skid;
    ifid_t        cap;

    assign pcp4      = pc + 32'd4;
    assign imem_addr = pc;

    // An issued request stays up until accepted, even if decode backs off.
    assign imem_req = (state == ST_FETCH) && (id_ready || pending);
    assign xfer     = imem_req && imem_ready;

    assign cap.valid = ~if_id_stall;
    assign cap.pc    = pc;
    assign cap.instr = imem_rdata;

    assign if_id_valid = ifid.valid;
    assign if_id_pc    = ifid.pc;
    assign if_id_instr = ifid.instr;

    pc_next_mux u_pc_next_mux (
        .pcsel      (pcsel),
        .pcp4       (pcp4),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .pcp4_hold  (pcp4_hold),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: if (xfer && !id_ready) state <= ST_SKID;
                ST_SKID:  if (id_ready) state <= ST_FETCH;
                default:  state <= ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            pending <= 1'b0;
        end else begin
            if (xfer) pc <= next_pc;
            pending <= imem_req && !imem_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid <= '0;
            skid <= '0;
        end else if (state == ST_SKID) begin
            if (id_ready) ifid <= skid;
        end else if (xfer) begin
            if (id_ready) ifid <= cap;
            else          skid <= cap;
        end else if (id_ready) begin
            ifid.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected transfers and IF/ID entries are
// queued by the stimulus and checked by an independent monitor.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_ifid_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pcsel;
    logic [31:0] br_target, jmp_target, pcp4_hold;
    logic        if_id_stall, id_ready;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata, pcp4;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic        mem_rdy;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] addr_q[$];
    exp_ifid_t   ifid_q[$];

    always #5 clk = ~clk;

    // Memory returns the inverted address as the instruction word.
    assign imem_ready = mem_rdy;
    assign imem_rdata = ~imem_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pcsel       (pcsel),
        .br_target   (br_target),
        .jmp_target  (jmp_target),
        .pcp4_hold   (pcp4_hold),
        .if_id_stall (if_id_stall),
        .id_ready    (id_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pcp4        (pcp4),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic [1:0] sel, input logic stall, input logic rdy, input logic idr);
        pcsel       = sel;
        if_id_stall = stall;
        mem_rdy     = rdy;
        id_ready    = idr;
        @(posedge clk);
        #1;
    endtask

    // One accepted fetch at addr; a non-stalled fetch must surface in IF/ID.
    task automatic xfer(input logic [31:0] addr, input logic [1:0] sel, input logic stall);
        exp_ifid_t e;
        addr_q.push_back(addr);
        if (!stall) begin
            e.pc    = addr;
            e.instr = ~addr;
            ifid_q.push_back(e);
        end
        step(sel, stall, 1'b1, 1'b1);
    endtask

    // Monitor: transfers and consumed IF/ID entries, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_req && imem_ready) begin
            if (addr_q.size() == 0) chk("unexpected_xfer_addr", imem_addr, 32'hxxxx_xxxx);
            else chk("xfer_addr", imem_addr, addr_q.pop_front());
        end
        if (rst_n === 1'b1 && if_id_valid && id_ready) begin
            if (ifid_q.size() == 0) begin
                chk("unexpected_ifid_pc", if_id_pc, 32'hxxxx_xxxx);
            end else begin
                exp_ifid_t e;
                e = ifid_q.pop_front();
                chk("ifid_pc", if_id_pc, e.pc);
                chk("ifid_instr", if_id_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pcsel = PCSEL_SEQ; br_target = '0; jmp_target = '0; pcp4_hold = '0;
        if_id_stall = 1'b0; id_ready = 1'b1; mem_rdy = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_ifid_pc", if_id_pc, 32'd0);
        chk("rst_ifid_instr", if_id_instr, 32'd0);
        chk("rst_pcp4", pcp4, 32'd4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        step(PCSEL_SEQ, 1'b0, 1'b1, 1'b1);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        xfer(32'h0, PCSEL_SEQ, 1'b0);
        xfer(32'h4, PCSEL_SEQ, 1'b0);
        xfer(32'h8, PCSEL_SEQ, 1'b0);
        xfer(32'hC, PCSEL_SEQ, 1'b0);
        br_target = 32'h80;
        xfer(32'h10, PCSEL_BR, 1'b1);
        chk("stall_valid", {31'd0, if_id_valid}, 32'd0);
        chk("stall_pc", if_id_pc, 32'h10);
        chk("br_addr", imem_addr, 32'h80);
        xfer(32'h80, PCSEL_SEQ, 1'b0);
        pcp4_hold = 32'h14;
        xfer(32'h84, PCSEL_HOLD, 1'b0);
        jmp_target = 32'h200;
        xfer(32'h14, PCSEL_JMP, 1'b0);
        xfer(32'h200, PCSEL_SEQ, 1'b0);
        jmp_target = 32'h20;
        xfer(32'h204, PCSEL_JMP, 1'b0);

        // Memory stalls at 0x20; redirects during the wait must be ignored.
        br_target = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h20);
            step(PCSEL_BR, 1'b0, 1'b0, 1'b1);
            chk("wait_bubble", {31'd0, if_id_valid}, 32'd0);
        end
        jmp_target = 32'h30;
        xfer(32'h20, PCSEL_JMP, 1'b0);

        // Decode backs off while 0x30 is outstanding: response lands in skid.
        chk("skid_pre_addr", imem_addr, 32'h30);
        step(PCSEL_SEQ, 1'b0, 1'b0, 1'b1);
        addr_q.push_back(32'h30);
        ifid_q.push_back('{pc: 32'h30, instr: ~32'h30});
        step(PCSEL_SEQ, 1'b0, 1'b1, 1'b0);
        chk("skid_req", {31'd0, imem_req}, 32'd0);
        chk("skid_valid", {31'd0, if_id_valid}, 32'd0);
        step(PCSEL_SEQ, 1'b0, 1'b1, 1'b0);
        chk("skid_hold_req", {31'd0, imem_req}, 32'd0);
        chk("skid_hold_pc", if_id_pc, 32'h20);
        step(PCSEL_SEQ, 1'b0, 1'b0, 1'b1);
        chk("drain_pc", if_id_pc, 32'h30);
        chk("drain_valid", {31'd0, if_id_valid}, 32'd1);
        chk("resume_addr", imem_addr, 32'h34);
        step(PCSEL_SEQ, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an outstanding request.
        chk("midwait_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("reboot_req", {31'd0, imem_req}, 32'd0);
        step(PCSEL_SEQ, 1'b0, 1'b1, 1'b1);
        chk("restart_addr", imem_addr, 32'h0);

        jmp_target = 32'hFFFF_FFFC;
        xfer(32'h0, PCSEL_JMP, 1'b0);
        chk("wrap_pcp4", pcp4, 32'h0);
        xfer(32'hFFFF_FFFC, PCSEL_SEQ, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);
        xfer(32'h0, PCSEL_SEQ, 1'b0);
        step(PCSEL_SEQ, 1'b0, 1'b0, 1'b1);
        step(PCSEL_SEQ, 1'b0, 1'b0, 1'b1);

        chk("addr_q_left", addr_q.size(), 32'd0);
        chk("ifid_q_left", ifid_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 pcsel  in  2  next-PC select from PC control: 0 seq, 1 branch, 2 jump, 3 hold.
REQ-005 br_target  in  32  speculative branch target; jmp_target  in  32  jump target.
REQ-006 pcp4_hold  in  32  saved fall-through address for branch-not-taken recovery.
REQ-007 if_id_stall  in  1  squash the instruction being written into IF/ID.
REQ-008 id_ready  in  1  decode can accept IF/ID contents this cycle.
REQ-009 imem_req  out  1; imem_addr  out  32; imem_ready  in  1; imem_rdata  in  32 -- instruction memory handshake.
REQ-010 pcp4  out  32  current PC + 4, fed back to PC control.
REQ-011 if_id_valid  out  1; if_id_pc  out  32; if_id_instr  out  32 -- IF/ID pipeline register.

Function
REQ-012 The block SHALL keep state in {BOOT, FETCH, SKID}.
REQ-013 pcp4 SHALL equal pc + 4 combinationally, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-014 imem_addr SHALL equal pc; imem_req SHALL be 1 only in FETCH, and only while id_ready=1 or a request is already outstanding.
REQ-015 Once imem_req is 1 and imem_ready is 0, imem_req and imem_addr SHALL stay stable until the transfer completes (req & ready at a rising edge).
REQ-016 BOOT SHALL last exactly one cycle after reset release, imem_req=0, then go to FETCH.
REQ-017 On a completed transfer, pc SHALL load: pcsel 0 -> pc+4, 1 -> br_target, 2 -> jmp_target, 3 -> pcp4_hold; pcsel is sampled only at that edge.
REQ-018 On a completed transfer with id_ready=1, IF/ID SHALL load pc, imem_rdata, and valid = ~if_id_stall, same edge (one-cycle fetch-to-IF/ID latency after ready).
REQ-019 On a completed transfer with id_ready=0, the response SHALL be captured in a skid register (pc, instr, ~if_id_stall), IF/ID held, state -> SKID.
REQ-020 In SKID imem_req SHALL be 0; when id_ready=1 the skid contents SHALL move into IF/ID and state -> FETCH.
REQ-021 With id_ready=1 and no completed transfer and not in SKID, if_id_valid SHALL load 0 (bubble); with id_ready=0, IF/ID SHALL hold unchanged.
REQ-022 pc SHALL change only on completed transfers; redirects on cycles without a transfer SHALL have no effect.
REQ-023 if_id_stall=1 with pcsel=0 SHALL still advance pc by 4 while writing a bubble.

Reset
REQ-024 While rst_n=0: pc=RESET_PC, state=BOOT, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_instr=0, skid cleared; an outstanding memory request SHALL be abandoned without waiting for imem_ready.
REQ-025 Reset release SHALL be sampled synchronously; first request issues on the second rising edge after release.

Structure
REQ-026 A shared package SHALL hold the pcsel encodings (PCSEL_SEQ, PCSEL_BR, PCSEL_JMP, PCSEL_HOLD), the state enum, and the default RESET_PC.
REQ-027 The next-PC 4:1 selection SHALL be a sub-module named pc_next_mux; all registers stay in fetch_unit.

Verification
REQ-028 Reset, memory ready always 1, pcsel=0, id_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; if_id_pc follows one cycle later, valid=1.
REQ-029 Transfer at pc=32'h10 with pcsel=1, br_target=32'h80, if_id_stall=1 -> next imem_addr 32'h80, IF/ID gets pc 32'h10 with valid=0.
REQ-030 Transfer at pc=32'h84 with pcsel=3, pcp4_hold=32'h14 -> next imem_addr 32'h14; pcsel=2, jmp_target=32'h200 -> next imem_addr 32'h200.
REQ-031 imem_ready low 3 cycles at addr 32'h20 -> req/addr stable 3 cycles, IF/ID bubbles, pc unchanged until completion.
REQ-032 id_ready drops during outstanding request at 32'h30, ready arrives -> state SKID, req=0, IF/ID held; id_ready rises -> IF/ID shows pc 32'h30, fetch resumes at 32'h34.
REQ-033 rst_n asserted mid-wait -> imem_req=0 and if_id_valid=0 immediately; restart at RESET_PC; pc 32'hFFFF_FFFC sequential -> next pc 0.
